// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, sequencer states and flag helpers
// used by the multi-cycle arithmetic blocks.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement overflow of an addition, judged on the sign bits alone.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out; the sequencer reuses
// one instance for every slice of the operands.
module add_chunk
   import alu_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] total_s;

   // Widen by one bit so the slice carry-out falls out of the MSB.
   always_comb begin
      total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   end

   assign sum  = total_s[CHUNK-1:0];
   assign cout = total_s[CHUNK];

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder: adds CHUNK bits per BUSY cycle through a rippled carry
// register and presents sum, carry, signed overflow and zero flag on a valid/ready port.
module add_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] addout,
   output logic             carry,
   output logic             ovf,
   output logic             flag
);

   localparam int NSTEP = WIDTH / CHUNK;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             cin_r;
   logic [WIDTH-1:0] addout_r;
   logic             carry_r;
   logic             ovf_r;
   logic             flag_r;
   logic             out_valid_r;
   logic             in_ready_r;

   logic             accept_s;
   logic             take_s;
   logic             last_s;
   logic [CHUNK-1:0] a_slice_s;
   logic [CHUNK-1:0] b_slice_s;
   logic [CHUNK-1:0] chunk_sum_s;
   logic             chunk_cout_s;
   logic [WIDTH-1:0] sum_nxt_s;

   assign accept_s = in_valid && in_ready_r;
   assign take_s   = out_valid_r && out_ready;
   assign last_s   = (state_r == BUSY) && (cnt_r == LAST_STEP);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: one BUSY cycle per slice, DONE holds until the result is taken.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = BUSY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == LAST_STEP) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = BUSY;
            end
         end
         DONE: begin
            if (take_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Select the operand slice addressed by the step counter.
   always_comb begin
      a_slice_s = {CHUNK{1'b0}};
      b_slice_s = {CHUNK{1'b0}};
      for (int i = 0; i < NSTEP; i++) begin
         a_slice_s = (cnt_r == CW'(i)) ? a_r[i*CHUNK +: CHUNK] : a_slice_s;
         b_slice_s = (cnt_r == CW'(i)) ? b_r[i*CHUNK +: CHUNK] : b_slice_s;
      end
   end

   add_chunk #(
      .CHUNK (CHUNK)
   ) u_add_chunk (
      .a    (a_slice_s),
      .b    (b_slice_s),
      .cin  (cin_r),
      .sum  (chunk_sum_s),
      .cout (chunk_cout_s)
   );

   // Partial sum with the current slice merged in; on the last step this is the full result.
   always_comb begin
      sum_nxt_s = sum_r;
      for (int i = 0; i < NSTEP; i++) begin
         sum_nxt_s[i*CHUNK +: CHUNK] = (cnt_r == CW'(i)) ? chunk_sum_s : sum_r[i*CHUNK +: CHUNK];
      end
   end

   // Operand capture, slice accumulation and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {CW{1'b0}};
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         sum_r    <= {WIDTH{1'b0}};
         cin_r    <= 1'b0;
         addout_r <= {WIDTH{1'b0}};
         carry_r  <= 1'b0;
         ovf_r    <= 1'b0;
         flag_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r   <= inA;
                  b_r   <= inB;
                  sum_r <= {WIDTH{1'b0}};
                  cnt_r <= {CW{1'b0}};
                  cin_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            BUSY: begin
               sum_r <= sum_nxt_s;
               cin_r <= chunk_cout_s;
               cnt_r <= cnt_r + CW'(1);
               // Flags are evaluated once on the complete sum, never per slice.
               if (last_s) begin
                  addout_r <= sum_nxt_s;
                  carry_r  <= chunk_cout_s;
                  ovf_r    <= add_ovf(a_r[WIDTH-1], b_r[WIDTH-1], sum_nxt_s[WIDTH-1]);
                  flag_r   <= (sum_nxt_s == {WIDTH{1'b0}});
               end else begin
                  addout_r <= addout_r;
               end
            end
            DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Handshake outputs registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         out_valid_r <= (state_nxt_s == DONE);
         in_ready_r  <= (state_nxt_s == IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign addout    = addout_r;
   assign carry     = carry_r;
   assign ovf       = ovf_r;
   assign flag      = flag_r;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: default 8-bit slices plus a single-step
// (CHUNK=32) instance, with a scoreboard of reference sums.
module tb_add_seq;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] sum;
      logic        c;
      logic        v;
      logic        z;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] inA, inB, addout;
   logic        carry, ovf, flag;
   logic        v32, rdy32, ov32, r32;
   logic [31:0] a32, b32, add32;
   logic        c32, o32, f32;

   res_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   add_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .inA(inA), .inB(inB), .out_valid(out_valid), .out_ready(out_ready),
      .addout(addout), .carry(carry), .ovf(ovf), .flag(flag));

   add_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
      .inA(a32), .inB(b32), .out_valid(ov32), .out_ready(r32),
      .addout(add32), .carry(c32), .ovf(o32), .flag(f32));

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      res_t r;
      s     = {1'b0, a} + {1'b0, b};
      r.sum = s[31:0];
      r.c   = s[32];
      r.v   = (a[31] == b[31]) && (s[31] != a[31]);
      r.z   = (s[31:0] == 32'd0);
      return r;
   endfunction

   // Handshake one operation into the 8-bit-slice DUT and wait for its result.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output res_t got, output res_t exp, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL accept_wait in_ready=%b want 1", in_ready);
      else n_pass++;
      in_valid = 1'b1; inA = a; inB = b;
      sb.push_back(model(a, b));
      @(negedge clk);
      in_valid = 1'b0; inA = $urandom; inB = $urandom;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!out_valid && lat < 50);
      got = {addout, carry, ovf, flag};
      exp = (sb.size() > 0) ? sb.pop_front() : res_t'(0);
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inA = 32'd0; inB = 32'd0;
      v32 = 1'b0; r32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
      #12;
      n_checks++;
      if ({out_valid, addout, carry, ovf, flag} !== 36'd0)
         $display("FAIL reset_outputs got ov=%b sum=%h c=%b v=%b z=%b want all 0",
                  out_valid, addout, carry, ovf, flag);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, rdy32, ov32} !== 4'b1010)
         $display("FAIL reset_release got rdy=%b ov=%b rdy32=%b ov32=%b want 1010",
                  in_ready, out_valid, rdy32, ov32);
      else n_pass++;
   endtask

   task automatic test_basic(input logic [31:0] a, input logic [31:0] b,
                             input res_t known, input string name);
      res_t got, exp;
      int   lat;
      run_op(a, b, got, exp, lat);
      n_checks++;
      if (lat !== 4) $display("FAIL %s_latency got %0d want 4", name, lat);
      else n_pass++;
      n_checks++;
      if (got !== exp) $display("FAIL %s_model got %h want %h", name, got, exp);
      else n_pass++;
      n_checks++;
      if (got !== known) $display("FAIL %s_value got %h want %h", name, got, known);
      else n_pass++;
      take_result();
   endtask

   task automatic test_back_to_back();
      res_t got, exp;
      int   lat;
      logic [31:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = $urandom; b = $urandom;
         if (i == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (i == 1) begin a = 32'h00FF_00FF; b = 32'hFF01_FF01; end
         run_op(a, b, got, exp, lat);
         n_checks++;
         if (got !== exp || lat !== 4)
            $display("FAIL b2b_%0d got %h lat %0d want %h lat 4", i, got, lat, exp);
         else n_pass++;
         take_result();
      end
   endtask

   task automatic test_backpressure();
      res_t got, exp;
      int   lat;
      run_op(32'h1234_5678, 32'h1111_1111, got, exp, lat);
      n_checks++;
      if (got !== exp) $display("FAIL bp_result got %h want %h", got, exp);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {addout, carry, ovf, flag} !== got)
            $display("FAIL bp_hold_%0d got ov=%b rdy=%b res=%h want ov=1 rdy=0 res=%h",
                     i, out_valid, in_ready, {addout, carry, ovf, flag}, got);
         else n_pass++;
         in_valid = (i % 2 == 0); inA = $urandom; inB = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
      take_result();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL bp_release got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
      else n_pass++;
      run_op(32'd3, 32'd4, got, exp, lat);
      n_checks++;
      if (got !== exp || got.sum !== 32'd7) $display("FAIL bp_next got %h want %h", got, exp);
      else n_pass++;
      take_result();
   endtask

   task automatic test_reset_mid_busy();
      res_t got, exp;
      int   lat;
      @(negedge clk);
      in_valid = 1'b1; inA = 32'h00FF_00FF; inB = 32'h0001_0001;
      sb.push_back(model(inA, inB));
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      n_checks++;
      if ({out_valid, addout, carry, ovf, flag} !== 36'd0)
         $display("FAIL midbusy_reset got ov=%b sum=%h c=%b v=%b z=%b want all 0",
                  out_valid, addout, carry, ovf, flag);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd1, 32'd1, got, exp, lat);
      n_checks++;
      if (got !== exp || got.sum !== 32'd2 || lat !== 4)
         $display("FAIL midbusy_after got %h lat %0d want %h lat 4", got, lat, exp);
      else n_pass++;
      take_result();
   endtask

   task automatic test_single_step();
      res_t got, exp;
      @(negedge clk);
      v32 = 1'b1; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
      sb.push_back(model(a32, b32));
      @(negedge clk);
      v32 = 1'b0; a32 = 32'h1; b32 = 32'h1;
      n_checks++;
      if (ov32 !== 1'b0 || rdy32 !== 1'b0)
         $display("FAIL c32_busy got ov=%b rdy=%b want ov=0 rdy=0", ov32, rdy32);
      else n_pass++;
      @(posedge clk);
      #1;
      got = {add32, c32, o32, f32};
      exp = (sb.size() > 0) ? sb.pop_front() : res_t'(0);
      n_checks++;
      if (ov32 !== 1'b1 || got !== exp || got !== {32'd0, 1'b1, 1'b1, 1'b1})
         $display("FAIL c32_result got ov=%b res=%h want ov=1 res=%h", ov32, got, exp);
      else n_pass++;
      @(negedge clk);
      r32 = 1'b1;
      @(posedge clk);
      #1;
      r32 = 1'b0;
      n_checks++;
      if (rdy32 !== 1'b1 || ov32 !== 1'b0)
         $display("FAIL c32_release got rdy=%b ov=%b want rdy=1 ov=0", rdy32, ov32);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic(32'd5, 32'd7, {32'h0000_000C, 1'b0, 1'b0, 1'b0}, "add5_7");
      test_basic(32'hFFFF_FFFF, 32'd1, {32'h0000_0000, 1'b1, 1'b0, 1'b1}, "ripple");
      test_basic(32'h7FFF_FFFF, 32'd1, {32'h8000_0000, 1'b0, 1'b1, 1'b0}, "sovf");
      test_back_to_back();
      test_backpressure();
      test_reset_mid_busy();
      test_single_step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
